move_encoder: RTL and testbench

MOVE_ENCODER -- requirements
Module: move_encoder

---
 rtl/move_encoder.sv | 157 +++++++++++++++
 tb/tb_move_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/move_encoder.sv
// rtl/move_encoder.sv - debounced four-button move encoder with one-shot handshake; MOVE_REPEAT_EN adds auto-repeat
module move_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_ack,
    output logic [2:0] move,
    output logic       move_valid
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LIMIT = DW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    localparam logic [2:0] CODE_NONE  = 3'b000;
    localparam logic [2:0] CODE_UP    = 3'b001;
    localparam logic [2:0] CODE_DOWN  = 3'b010;
    localparam logic [2:0] CODE_LEFT  = 3'b011;
    localparam logic [2:0] CODE_RIGHT = 3'b100;

    // bit order: 0 up, 1 down, 2 left, 3 right
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [DW-1:0] deb_cnt [4];
    logic [1:0]    state;
    logic [2:0]    prio_code;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Counter restarts whenever the synced input agrees with the accepted value,
    // so any glitch shorter than the full window is forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= 4'b0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LIMIT) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        prio_code = CODE_NONE;
        if (deb[0])      prio_code = CODE_UP;
        else if (deb[1]) prio_code = CODE_DOWN;
        else if (deb[2]) prio_code = CODE_LEFT;
        else if (deb[3]) prio_code = CODE_RIGHT;
    end

`ifdef MOVE_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LIMIT = RW'(REPEAT_CYCLES);

    logic [2:0]    last_code;
    logic [RW-1:0] rep_cnt;
    logic          last_pressed;

    always_comb begin
        last_pressed = 1'b0;
        case (last_code)
            CODE_UP:    last_pressed = deb[0];
            CODE_DOWN:  last_pressed = deb[1];
            CODE_LEFT:  last_pressed = deb[2];
            CODE_RIGHT: last_pressed = deb[3];
            default:    last_pressed = 1'b0;
        endcase
    end
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            move       <= CODE_NONE;
            move_valid <= 1'b0;
`ifdef MOVE_REPEAT_EN
            last_code  <= CODE_NONE;
            rep_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|deb) begin
                        move       <= prio_code;
                        move_valid <= 1'b1;
                        state      <= ST_PENDING;
`ifdef MOVE_REPEAT_EN
                        last_code  <= prio_code;
`endif
                    end
                end
                ST_PENDING: begin
                    if (move_ack) begin
                        move       <= CODE_NONE;
                        move_valid <= 1'b0;
                        state      <= ST_HELD;
`ifdef MOVE_REPEAT_EN
                        rep_cnt    <= '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (deb == 4'b0) begin
                        state <= ST_IDLE;
                    end
`ifdef MOVE_REPEAT_EN
                    else if (!last_pressed) begin
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_LIMIT) begin
                        move       <= last_code;
                        move_valid <= 1'b1;
                        state      <= ST_PENDING;
                        rep_cnt    <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state      <= ST_IDLE;
                    move       <= CODE_NONE;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_move_encoder.sv
// tb/tb_move_encoder.sv - scoreboard bench for move_encoder (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
module tb_move_encoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       move_ack;
    logic [2:0] move;
    logic       move_valid;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       prev_valid = 1'b0;
    logic [2:0] prev_move = 3'b000;

    move_encoder #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .move_ack(move_ack), .move(move), .move_valid(move_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Input driven just after edge k is sampled at k+1 and shows up as move_valid after edge k+8.
    function automatic void expect_move(input logic [2:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (!move_valid && move != 3'b000) begin
                bad++;
                $display("FAIL idle_zero cyc=%0d move=%b required=000", cyc, move);
            end
            if (prev_valid && move_valid) begin
                total++;
                if (move != prev_move) begin
                    bad++;
                    $display("FAIL pending_stable cyc=%0d move=%b required=%b", cyc, move, prev_move);
                end
            end
            if (move_valid && !prev_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_move cyc=%0d move=%b required=none", cyc, move);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (move != e.code || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL move_event move=%b cyc=%0d required move=%b cyc=%0d",
                                 move, cyc, e.code, e.cyc);
                    end
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_move cyc=%0d required move=%b at cyc=%0d", cyc, e.code, e.cyc);
            end
        end
        prev_valid = reset ? 1'b0 : move_valid;
        prev_move  = move;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [2:0] m, input logic v);
        total++;
        if (move !== m || move_valid !== v) begin
            bad++;
            $display("FAIL %s move=%b valid=%b required move=%b valid=%b", name, move, move_valid, m, v);
        end
    endtask

    initial begin
        int k;
        reset = 1'b1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        move_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_out("reset_state", 3'b000, 1'b0);
        step(2);
        reset = 1'b0;
        step(5);

        // right with ack tied high: one-cycle pulse of 100
        move_ack = 1'b1;
        btn_right = 1'b1;
        k = cyc;
        expect_move(3'b100, k + 8);
        step(9);
        @(negedge clk);
        check_out("right_one_cycle", 3'b000, 1'b0);
        step(1);
        btn_right = 1'b0;
        step(20);

        // 3-cycle glitch on up is filtered
        btn_up = 1'b1;
        step(3);
        btn_up = 1'b0;
        step(20);

        // left+down together, no ack: down wins and holds
        move_ack = 1'b0;
        btn_left = 1'b1;
        btn_down = 1'b1;
        k = cyc;
        expect_move(3'b010, k + 8);
        step(30);
        @(negedge clk);
        check_out("down_held", 3'b010, 1'b1);
        step(1);
        move_ack = 1'b1;
        @(posedge clk);
        #1;
        move_ack = 1'b0;
        @(negedge clk);
        check_out("down_acked", 3'b000, 1'b0);
        step(1);
        btn_left = 1'b0;
        btn_down = 1'b0;
        step(20);

        // hold up for 100 cycles with ack high
        move_ack = 1'b1;
        btn_up = 1'b1;
        k = cyc;
        expect_move(3'b001, k + 8);
`ifdef MOVE_REPEAT_EN
        for (int i = 1; i <= 5; i++) expect_move(3'b001, k + 8 + 18 * i);
`endif
        step(100);
        btn_up = 1'b0;
        step(30);

        // reset during pending left discards it; still-held left reports again
        move_ack = 1'b0;
        btn_left = 1'b1;
        k = cyc;
        expect_move(3'b011, k + 8);
        step(12);
        @(negedge clk);
        check_out("left_pending", 3'b011, 1'b1);
        step(1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("reset_mid_pending", 3'b000, 1'b0);
        step(2);
        reset = 1'b0;
        k = cyc;
        expect_move(3'b011, k + 8);
        step(12);
        move_ack = 1'b1;
        step(1);
        move_ack = 1'b0;
        btn_left = 1'b0;
        step(25);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
